// File: rtl/key_debounce_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, per-key debounce FSM, active-high
// stable level for the PIO in_port plus registered press/release pulses.
module key_debounce_conditioner #(
    parameter int N_KEYS          = 2,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [N_KEYS-1:0] IDLE_LVL = {N_KEYS{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0]  TARGET   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);

    logic [N_KEYS-1:0] s1_q;
    logic [N_KEYS-1:0] s2_q;
    logic [N_KEYS-1:0] p;

    // s1 may go metastable; only s2 reads it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= IDLE_LVL;
            s2_q <= IDLE_LVL;
        end else begin
            s1_q <= key_raw;
            s2_q <= s1_q;
        end
    end

    assign p = s2_q ^ IDLE_LVL;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] cnt_inc;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;

        assign cnt_inc = cnt_q + ONE;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        // cnt holds the number of consecutive new-level samples already seen; the
        // change is accepted on the sample that brings that number to DEBOUNCE_CYCLES.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (p[i]) begin
                        if (TARGET == ONE) begin
                            state_d = PRESSED;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = PRESS_WAIT;
                            cnt_d   = ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!p[i]) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_inc == TARGET) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!p[i]) begin
                        if (TARGET == ONE) begin
                            state_d = RELEASED;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (p[i]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc == TARGET) begin
                        state_d = RELEASED;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
    end

endmodule

// File: tb/tb_key_debounce_conditioner.sv
// Directed bench for key_debounce_conditioner with DEBOUNCE_CYCLES = 8, active-low pins.
module tb_key_debounce_conditioner;

    logic       clk;
    logic       reset_n;
    logic [1:0] key_raw;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;

    int n_chk;
    int n_err;
    int press_cnt [2];
    int rel_cnt   [2];
    int both_cnt;

    key_debounce_conditioner #(
        .N_KEYS         (2),
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        for (int j = 0; j < 2; j++) begin
            press_cnt[j] = 0;
            rel_cnt[j]   = 0;
        end
    endtask

    // Advance n edges, sampling 1 time unit after each edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < 2; j++) begin
                press_cnt[j] += int'(key_press[j]);
                rel_cnt[j]   += int'(key_release[j]);
            end
            if ((key_press & key_release) != 2'b00) both_cnt++;
        end
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        both_cnt = 0;
        clr_counts();

        // Reset with both pins idle high
        reset_n = 1'b0;
        key_raw = 2'b11;
        #1;
        chk("rst_level", 32'(key_level), 0);
        chk("rst_press", 32'(key_press), 0);
        chk("rst_release", 32'(key_release), 0);
        step(3);
        reset_n = 1'b1;
        clr_counts();
        step(50);
        chk("idle_level", 32'(key_level), 0);
        chk("idle_press_cnt", 32'(press_cnt[0] + press_cnt[1]), 0);
        chk("idle_rel_cnt", 32'(rel_cnt[0] + rel_cnt[1]), 0);

        // Single key press: level rises on the 10th edge
        key_raw = 2'b10;
        clr_counts();
        step(9);
        chk("p0_level_e9", 32'(key_level), 0);
        chk("p0_press_e9", 32'(press_cnt[0]), 0);
        step(1);
        chk("p0_level_e10", 32'(key_level), 1);
        chk("p0_press_e10", 32'(key_press), 1);
        step(1);
        chk("p0_press_e11", 32'(key_press), 0);
        step(20);
        chk("p0_level_hold", 32'(key_level), 1);
        chk("p0_press_cnt", 32'(press_cnt[0]), 1);
        key_raw = 2'b11;
        clr_counts();
        step(9);
        chk("r0_level_e9", 32'(key_level), 1);
        step(1);
        chk("r0_level_e10", 32'(key_level), 0);
        chk("r0_release_e10", 32'(key_release), 1);
        step(1);
        chk("r0_release_e11", 32'(key_release), 0);
        step(10);

        // Bounce 0,1,0,1 with 3-cycle phases, then settle pressed
        clr_counts();
        for (int ph = 0; ph < 4; ph++) begin
            key_raw = (ph % 2 == 0) ? 2'b10 : 2'b11;
            step(3);
        end
        key_raw = 2'b10;
        step(9);
        chk("bnc_level_e9", 32'(key_level), 0);
        chk("bnc_press_e9", 32'(press_cnt[0]), 0);
        step(1);
        chk("bnc_level_e10", 32'(key_level), 1);
        chk("bnc_press_e10", 32'(key_press), 1);
        step(20);
        chk("bnc_press_cnt", 32'(press_cnt[0]), 1);
        key_raw = 2'b11;
        step(12);
        chk("bnc_rel_level", 32'(key_level), 0);
        chk("bnc_rel_cnt", 32'(rel_cnt[0]), 1);

        // Both keys pressed together, released 40 cycles later
        key_raw = 2'b00;
        clr_counts();
        step(9);
        chk("both_level_e9", 32'(key_level), 0);
        step(1);
        chk("both_level_e10", 32'(key_level), 3);
        chk("both_press_e10", 32'(key_press), 3);
        step(30);
        key_raw = 2'b11;
        step(9);
        chk("both_rlevel_e9", 32'(key_level), 3);
        step(1);
        chk("both_rlevel_e10", 32'(key_level), 0);
        chk("both_release_e10", 32'(key_release), 3);
        step(1);
        chk("both_release_e11", 32'(key_release), 0);
        chk("both_press_cnt", 32'(press_cnt[0] * 10 + press_cnt[1]), 11);
        step(5);

        // Reset during PRESS_WAIT of key 0 while key 1 is already pressed
        key_raw = 2'b01;
        step(12);
        chk("k1_level", 32'(key_level), 2);
        key_raw = 2'b00;
        step(7);
        reset_n = 1'b0;
        #1;
        chk("midrst_level", 32'(key_level), 0);
        step(3);
        chk("midrst_hold", 32'(key_level | key_press), 0);
        reset_n = 1'b1;
        clr_counts();
        step(1);
        chk("postrst_e1_press", 32'(key_press), 0);
        step(8);
        chk("postrst_e9", 32'(key_level), 0);
        chk("postrst_press_e9", 32'(press_cnt[0] + press_cnt[1]), 0);
        step(1);
        chk("postrst_level_e10", 32'(key_level), 3);
        chk("postrst_press_e10", 32'(key_press), 3);
        step(10);

        // 7-cycle release glitch on key 0 is rejected
        clr_counts();
        key_raw = 2'b01;
        step(7);
        key_raw = 2'b00;
        step(20);
        chk("gl7_level", 32'(key_level), 3);
        chk("gl7_rel_cnt", 32'(rel_cnt[0]), 0);

        // 8-cycle release on key 0 is accepted
        clr_counts();
        key_raw = 2'b01;
        step(8);
        key_raw = 2'b00;
        step(1);
        chk("gl8_level_e9", 32'(key_level), 3);
        chk("gl8_rel_e9", 32'(rel_cnt[0]), 0);
        step(1);
        chk("gl8_level_e10", 32'(key_level), 2);
        chk("gl8_release_e10", 32'(key_release), 1);
        step(20);
        chk("gl8_repress_level", 32'(key_level), 3);
        chk("gl8_repress_cnt", 32'(press_cnt[0]), 1);
        chk("gl8_k1_rel_cnt", 32'(rel_cnt[1]), 0);

        chk("press_release_overlap", 32'(both_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
